// File: rtl/if_id_pipe_buf_if.sv
// IF->ID handshake bundle: fetch side drives the master modport, the pipeline buffer uses slave.
interface if_id_pipe_buf_if #(
  parameter int INST_W = 32,
  parameter int ADDR_W = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [INST_W-1:0] inst_i;
  logic [ADDR_W-1:0] pc_i;
  logic              flush_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] pc_o;
  logic [1:0]        occupancy_o;

  modport master (
    output in_valid_i, inst_i, pc_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, inst_o, pc_o, occupancy_o
  );

  modport slave (
    input  in_valid_i, inst_i, pc_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, inst_o, pc_o, occupancy_o
  );
endinterface

// File: rtl/if_id_pipe_buf.sv
// IF->ID pipeline buffer: valid/ready handshake, optional skid entry, flush and global rdy freeze.
module if_id_pipe_buf #(
  parameter int INST_W  = 32,
  parameter int ADDR_W  = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic dclk,
  input  logic rst,
  input  logic rdy,
  if_id_pipe_buf_if.slave bus
);
  logic              main_v_r, skid_v_r;
  logic [INST_W-1:0] main_inst_r, skid_inst_r;
  logic [ADDR_W-1:0] main_pc_r, skid_pc_r;
  logic [1:0]        occ_r;

  logic              main_v_nx_s, skid_v_nx_s;
  logic [INST_W-1:0] main_inst_nx_s, skid_inst_nx_s;
  logic [ADDR_W-1:0] main_pc_nx_s, skid_pc_nx_s;
  logic [1:0]        occ_nx_s;
  logic              in_ready_s, accept_s, pop_s;

  // Ready: with the skid entry it depends on registered state only, without it ID's ready passes through.
  always_comb begin
    if (SKID_EN) begin
      in_ready_s = rdy & ~skid_v_r & ~bus.flush_i;
    end else begin
      in_ready_s = rdy & ~bus.flush_i & (~main_v_r | bus.out_ready_i);
    end
    accept_s = bus.in_valid_i & in_ready_s;
    pop_s    = main_v_r & bus.out_ready_i & rdy & ~bus.flush_i;
  end

  // Next-state for the main/skid entries; flush wins over the freeze.
  always_comb begin
    main_v_nx_s    = main_v_r;
    skid_v_nx_s    = skid_v_r;
    main_inst_nx_s = main_inst_r;
    main_pc_nx_s   = main_pc_r;
    skid_inst_nx_s = skid_inst_r;
    skid_pc_nx_s   = skid_pc_r;
    if (bus.flush_i) begin
      main_v_nx_s    = 1'b0;
      skid_v_nx_s    = 1'b0;
      main_inst_nx_s = {INST_W{1'b0}};
      main_pc_nx_s   = {ADDR_W{1'b0}};
      skid_inst_nx_s = {INST_W{1'b0}};
      skid_pc_nx_s   = {ADDR_W{1'b0}};
    end else if (rdy) begin
      if (SKID_EN) begin
        if (pop_s && skid_v_r) begin
          // in_ready was low, so nothing can be accepted alongside the skid drain
          main_inst_nx_s = skid_inst_r;
          main_pc_nx_s   = skid_pc_r;
          skid_v_nx_s    = 1'b0;
        end else if (pop_s && accept_s) begin
          main_inst_nx_s = bus.inst_i;
          main_pc_nx_s   = bus.pc_i;
        end else if (pop_s) begin
          main_v_nx_s = 1'b0;
        end else if (accept_s && main_v_r) begin
          skid_inst_nx_s = bus.inst_i;
          skid_pc_nx_s   = bus.pc_i;
          skid_v_nx_s    = 1'b1;
        end else if (accept_s) begin
          main_inst_nx_s = bus.inst_i;
          main_pc_nx_s   = bus.pc_i;
          main_v_nx_s    = 1'b1;
        end else begin
          main_v_nx_s = main_v_r;
        end
      end else begin
        if (accept_s) begin
          main_inst_nx_s = bus.inst_i;
          main_pc_nx_s   = bus.pc_i;
          main_v_nx_s    = 1'b1;
        end else if (pop_s) begin
          main_v_nx_s = 1'b0;
        end else begin
          main_v_nx_s = main_v_r;
        end
      end
    end else begin
      main_v_nx_s = main_v_r;
    end
    occ_nx_s = {1'b0, main_v_nx_s} + {1'b0, skid_v_nx_s};
  end

  // State registers; reset overrides flush and rdy.
  always_ff @(posedge dclk) begin
    if (rst) begin
      main_v_r    <= 1'b0;
      skid_v_r    <= 1'b0;
      main_inst_r <= {INST_W{1'b0}};
      main_pc_r   <= {ADDR_W{1'b0}};
      skid_inst_r <= {INST_W{1'b0}};
      skid_pc_r   <= {ADDR_W{1'b0}};
      occ_r       <= 2'd0;
    end else begin
      main_v_r    <= main_v_nx_s;
      skid_v_r    <= skid_v_nx_s;
      main_inst_r <= main_inst_nx_s;
      main_pc_r   <= main_pc_nx_s;
      skid_inst_r <= skid_inst_nx_s;
      skid_pc_r   <= skid_pc_nx_s;
      occ_r       <= occ_nx_s;
    end
  end

  assign bus.in_ready_o  = in_ready_s;
  assign bus.out_valid_o = main_v_r;
  assign bus.inst_o      = main_inst_r;
  assign bus.pc_o        = main_pc_r;
  assign bus.occupancy_o = occ_r;
endmodule

// File: tb/tb_if_id_pipe_buf.sv
// Drives identical stimulus into a skid (SKID_EN=1) and a single-entry (SKID_EN=0) buffer, each checked against a small FIFO model.
module tb_if_id_pipe_buf;
  logic        dclk = 1'b0;
  logic        rst = 1'b1, rdy = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] inst = 32'd0, pc = 32'd0;
  int          total = 0, bad = 0;
  bit          armed = 1'b0;

  // model: per DUT k, FIFO entries [0]=head, count, and the head value left behind after the last pop
  logic [31:0] m_inst [2][2];
  logic [31:0] m_pc   [2][2];
  int          cnt    [2];
  logic [31:0] last_inst [2];
  logic [31:0] last_pc   [2];
  bit          rdy_m  [2];

  always #5 dclk = ~dclk;

  if_id_pipe_buf_if #(.INST_W(32), .ADDR_W(32)) bus1 ();
  if_id_pipe_buf_if #(.INST_W(32), .ADDR_W(32)) bus0 ();

  assign bus1.in_valid_i = in_valid;
  assign bus1.inst_i = inst;
  assign bus1.pc_i = pc;
  assign bus1.flush_i = flush;
  assign bus1.out_ready_i = out_ready;
  assign bus0.in_valid_i = in_valid;
  assign bus0.inst_i = inst;
  assign bus0.pc_i = pc;
  assign bus0.flush_i = flush;
  assign bus0.out_ready_i = out_ready;

  if_id_pipe_buf #(.INST_W(32), .ADDR_W(32), .SKID_EN(1'b1)) dut1 (
    .dclk(dclk), .rst(rst), .rdy(rdy), .bus(bus1));
  if_id_pipe_buf #(.INST_W(32), .ADDR_W(32), .SKID_EN(1'b0)) dut0 (
    .dclk(dclk), .rst(rst), .rdy(rdy), .bus(bus0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mready(input int k);
    if (k == 1) return rdy && !flush && (cnt[1] < 2);
    return rdy && !flush && ((cnt[0] == 0) || out_ready);
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst || flush) begin
        cnt[k] = 0;
        last_inst[k] = 32'd0;
        last_pc[k] = 32'd0;
      end else if (rdy) begin
        if (cnt[k] > 0 && out_ready) begin
          last_inst[k] = m_inst[k][0];
          last_pc[k] = m_pc[k][0];
          m_inst[k][0] = m_inst[k][1];
          m_pc[k][0] = m_pc[k][1];
          cnt[k]--;
        end
        if (in_valid && rdy_m[k]) begin
          m_inst[k][cnt[k]] = inst;
          m_pc[k][cnt[k]] = pc;
          cnt[k]++;
        end
      end
    end
  endtask

  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) rdy_m[k] = mready(k);
    if (armed) begin
      chk("in_ready_skid", {63'd0, bus1.in_ready_o}, {63'd0, rdy_m[1]});
      chk("in_ready_single", {63'd0, bus0.in_ready_o}, {63'd0, rdy_m[0]});
    end
    @(posedge dclk);
    if (rst) armed = 1'b1;
    model_edge();
    #1;
    chk("valid_skid", {63'd0, bus1.out_valid_o}, {63'd0, cnt[1] > 0});
    chk("inst_skid", {32'd0, bus1.inst_o}, {32'd0, (cnt[1] > 0) ? m_inst[1][0] : last_inst[1]});
    chk("pc_skid", {32'd0, bus1.pc_o}, {32'd0, (cnt[1] > 0) ? m_pc[1][0] : last_pc[1]});
    chk("occ_skid", {62'd0, bus1.occupancy_o}, 64'(cnt[1]));
    chk("valid_single", {63'd0, bus0.out_valid_o}, {63'd0, cnt[0] > 0});
    chk("inst_single", {32'd0, bus0.inst_o}, {32'd0, (cnt[0] > 0) ? m_inst[0][0] : last_inst[0]});
    chk("pc_single", {32'd0, bus0.pc_o}, {32'd0, (cnt[0] > 0) ? m_pc[0][0] : last_pc[0]});
    chk("occ_single", {62'd0, bus0.occupancy_o}, 64'(cnt[0]));
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    inst = i;
    pc = p;
    step();
  endtask

  initial begin
    cnt[0] = 0;
    cnt[1] = 0;
    // reset
    step();
    rst = 1'b0;
    // stream at full rate
    out_ready = 1'b1;
    push(32'h0000_0013, 32'h0);
    chk("stream_pc0", {32'd0, bus1.pc_o}, 64'h0);
    push(32'h0010_0093, 32'h4);
    chk("stream_pc1", {32'd0, bus1.pc_o}, 64'h4);
    push(32'h0020_0113, 32'h8);
    chk("stream_inst2", {32'd0, bus0.inst_o}, 64'h0020_0113);
    chk("stream_occ", {62'd0, bus1.occupancy_o}, 64'd1);
    in_valid = 1'b0;
    step();
    // backpressure into the skid entry
    out_ready = 1'b0;
    push(32'hA0, 32'h0);
    push(32'hA4, 32'h4);
    push(32'hA8, 32'h8);
    chk("bp_occ", {62'd0, bus1.occupancy_o}, 64'd2);
    chk("bp_ready", {63'd0, bus1.in_ready_o}, 64'd0);
    out_ready = 1'b1;
    step();
    chk("bp_rel0", {32'd0, bus1.pc_o}, 64'h4);
    step();
    chk("bp_rel1", {32'd0, bus1.pc_o}, 64'h8);
    in_valid = 1'b0;
    step();
    chk("bp_empty", {63'd0, bus1.out_valid_o}, 64'd0);
    // flush with a full buffer and a valid input
    out_ready = 1'b0;
    push(32'hB8, 32'h18);
    push(32'hBC, 32'h1C);
    flush = 1'b1;
    push(32'hC0, 32'h20);
    flush = 1'b0;
    chk("fl_valid", {63'd0, bus1.out_valid_o}, 64'd0);
    chk("fl_occ", {62'd0, bus1.occupancy_o}, 64'd0);
    chk("fl_inst", {32'd0, bus1.inst_o}, 64'd0);
    push(32'hE0, 32'h40);
    chk("fl_after", {32'd0, bus1.pc_o}, 64'h40);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    // freeze
    out_ready = 1'b0;
    push(32'hD0, 32'h10);
    in_valid = 1'b0;
    step();
    rdy = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frz_pc", {32'd0, bus1.pc_o}, 64'h10);
      chk("frz_valid", {63'd0, bus1.out_valid_o}, 64'd1);
    end
    rdy = 1'b1;
    step();
    chk("frz_pop", {63'd0, bus1.out_valid_o}, 64'd0);
    // reset mid-operation overriding flush and rdy
    out_ready = 1'b0;
    push(32'hF0, 32'h50);
    push(32'hF4, 32'h54);
    chk("rm_occ2", {62'd0, bus1.occupancy_o}, 64'd2);
    rst = 1'b1;
    flush = 1'b1;
    rdy = 1'b0;
    step();
    chk("rm_occ", {62'd0, bus1.occupancy_o}, 64'd0);
    chk("rm_pc", {32'd0, bus1.pc_o}, 64'd0);
    chk("rm_inst", {32'd0, bus1.inst_o}, 64'd0);
    rst = 1'b0;
    flush = 1'b0;
    rdy = 1'b1;
    // single-entry: ready drops combinationally while full, then full-rate replacement
    push(32'h160, 32'h60);
    pc = 32'h64;
    inst = 32'h164;
    #1;
    chk("single_full_ready", {63'd0, bus0.in_ready_o}, 64'd0);
    out_ready = 1'b1;
    step();
    chk("single_repl0", {32'd0, bus0.pc_o}, 64'h64);
    push(32'h168, 32'h68);
    chk("single_repl1", {32'd0, bus0.pc_o}, 64'h68);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 29) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      inst = $urandom;
      pc = $urandom & 32'hFFFF_FFFC;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_id_pipe_buf.md
Name: if_id_pipe_buf

Overview:
Parametrised IF→ID pipeline buffer and the successor of the plain IF/ID latch. It carries the instruction word and its PC through a valid/ready handshake instead of an unconditional copy. Features: optional 2-entry skid storage, synchronous flush for branch/jump redirect, and a global `rdy` freeze. It sits between the fetch unit and the decoder; the decoder's stall maps onto `out_ready_i`.

Parameters:
- INST_W, 32, instruction word width.
- ADDR_W, 32, PC width.
- SKID_EN, 1
  - 1: 2-entry buffer (main + skid). `in_ready_o` is a function of registered state only.
  - 0: single entry; `in_ready_o` depends combinationally on `out_ready_i`.

Ports:
- dclk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready. 0 = freeze all state except flush.
- in_valid_i  in  1  fetch presents a valid instruction.
- in_ready_o  out  1  buffer can accept this cycle.
- inst_i  in  INST_W  instruction from IF.
- pc_i  in  ADDR_W  PC of inst_i.
- flush_i  in  1  discard all buffered and incoming entries.
- out_valid_o  out  1  inst_o/pc_o valid for ID.
- out_ready_i  in  1  ID consumes this cycle.
- inst_o  out  INST_W  instruction to ID (main entry).
- pc_o  out  ADDR_W  PC to ID (main entry).
- occupancy_o  out  2  number of valid entries (0..2; max 1 when SKID_EN=0).

Behaviour:
- Reset (`rst`=1 at edge):
  - main_v=0, skid_v=0.
  - All data registers = 0, so `inst_o`=0 and `pc_o`=0.
  - `out_valid_o`=0, `occupancy_o`=0.
  - `rst` overrides flush and rdy.
- Definitions:
  - accept = `in_valid_i` & `in_ready_o`
  - pop = main_v & `out_ready_i` & `rdy` & !`flush_i`
  - `out_valid_o` = main_v; `inst_o`/`pc_o` come directly from main registers (registered outputs).
- `in_ready_o`:
  - SKID_EN=1: `rdy` & !skid_v & !`flush_i`.
  - SKID_EN=0: `rdy` & !`flush_i` & (!main_v | `out_ready_i`).
- Flush (`flush_i`=1, not in reset):
  - Next cycle main_v=0, skid_v=0, data registers = 0.
  - Input that cycle is dropped (`in_ready_o`=0 makes accept impossible).
  - Honoured even when `rdy`=0.
- Freeze (`rdy`=0, no flush): no accept, no pop; all registers hold; outputs keep their values.
- SKID_EN=1 update rules (`rdy`=1, no flush):
  - main empty & accept → main <= input.
  - main full & pop & accept & !skid_v → main <= input.
  - main full & !pop & accept → skid <= input, skid_v=1.
  - pop & skid_v → main <= skid, skid_v=0. No accept is possible, since `in_ready_o`=0.
  - pop & no accept & !skid_v → main_v=0; data holds its stale value.
- SKID_EN=0: main <= input on accept; main_v=0 on pop without accept.
- Ordering: strict FIFO. No entry is ever dropped or duplicated except by flush/reset.
- Latency: 1 cycle from accept to `out_valid_o`; throughput 1 per cycle when `out_ready_i`=1.
- `occupancy_o` = main_v + skid_v, registered, consistent with the valid bits in the same cycle.
- Skid invariant: skid_v=1 implies main_v=1; no transition may violate it.

Test Plan:
- Stream: reset, then `in_valid_i`=1 with `out_ready_i`=1, inst 0x00000013/0x00100093/0x00200113, PC 0x0/0x4/0x8 → same triples on `inst_o`/`pc_o` on cycles 1,2,3; `occupancy_o`=1 throughout; `in_ready_o`=1.
- Backpressure (SKID_EN=1):
  - Hold `out_ready_i`=0 while pushing PC 0x0, 0x4, 0x8.
  - PC 0x0 lands in main, 0x4 in skid; `occupancy_o`=2 and `in_ready_o`=0, so 0x8 is held by IF.
  - Release → outputs 0x0, 0x4, 0x8 in order with no gaps.
- Flush: with `occupancy_o`=2, assert `flush_i` for 1 cycle while `in_valid_i`=1 (PC 0x20).
  - Next cycle `out_valid_o`=0, `occupancy_o`=0, `inst_o`=0.
  - PC 0x20 never appears.
  - Following cycle accepts PC 0x40 normally.
- Freeze: hold `rdy`=0 for 5 cycles with main holding PC 0x10 and `out_ready_i`=1 → `pc_o` stays 0x10, `out_valid_o` stays 1, `in_ready_o`=0; after `rdy`=1, PC 0x10 pops on the first cycle.
- Reset mid-operation: `rst`=1 for 1 cycle with `occupancy_o`=2, `flush_i`=1, `rdy`=0 → next cycle all outputs 0 and `occupancy_o`=0.
- SKID_EN=0 variant: same stream as the first scenario gives identical output. With `out_ready_i`=0 and main full, `in_ready_o`=0 in the same cycle; `out_ready_i`=1 with `in_valid_i`=1 replaces the entry at full rate.
